// File: rtl/rv_bus_pkg.sv
// Shared bus definitions: burst codes, burst-to-beat conversion and arbiter states.
package rv_bus_pkg;

  localparam int BEAT_W = 5;

  typedef enum logic [1:0] {
    BURST_SINGLE = 2'b00,
    BURST_4      = 2'b01,
    BURST_8      = 2'b10,
    BURST_16     = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  function automatic logic [BEAT_W-1:0] burst_beats(input logic [1:0] code);
    case (burst_e'(code))
      BURST_SINGLE: burst_beats = 5'd1;
      BURST_4:      burst_beats = 5'd4;
      BURST_8:      burst_beats = 5'd8;
      BURST_16:     burst_beats = 5'd16;
      default:      burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Remaining-beat counter: loaded with beats-1 at grant, decremented on each completed beat.
module burst_beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the unified memory port: data has priority, a starvation
// counter forces an instruction grant, and ownership is held for the whole burst.
module mem_bus_arbiter
  import rv_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  input  logic [1:0]  instr_burst,
  input  logic [3:0]  instr_bstrobe,
  output logic [31:0] instr_data,
  output logic        instr_ready,
  output logic        instr_stall,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write_data,
  input  logic [1:0]  data_burst,
  input  logic [3:0]  data_bstrobe,
  output logic [31:0] data_read_data,
  output logic        data_ready,
  output logic        data_stall,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_burst,
  output logic [3:0]  mem_bstrobe,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall,
  input  logic        mem_ready,
  output logic        grant_data
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       r_state, w_next;
  logic [SC_W-1:0]  r_starve;
  logic             r_mem_req, r_mem_write, r_grant_data;
  logic [31:0]      r_mem_addr;
  logic [1:0]       r_mem_burst;
  logic [3:0]       r_mem_bstrobe;
  logic             w_force_instr, w_grant_data, w_grant_instr;
  logic             w_beat_dec, w_cnt_last, w_last_beat;
  logic [CNT_W-1:0] w_load_val;

  assign w_force_instr = instr_req && (r_starve == SC_W'(STARVE_LIMIT));
  assign w_grant_data  = (r_state == ARB_IDLE) && data_req && !w_force_instr;
  assign w_grant_instr = (r_state == ARB_IDLE) && !w_grant_data && instr_req;
  assign w_beat_dec    = (r_state != ARB_IDLE) && mem_ready;
  assign w_last_beat   = w_beat_dec && w_cnt_last;
  assign w_load_val    = CNT_W'(burst_beats(w_grant_data ? data_burst : instr_burst) - 5'd1);

  burst_beat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant_data || w_grant_instr),
    .i_load_val (w_load_val),
    .i_dec      (w_beat_dec),
    .o_last     (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_data)       w_next = ARB_DATA;
        else if (w_grant_instr) w_next = ARB_INSTR;
      end
      ARB_INSTR, ARB_DATA: begin
        if (w_last_beat) w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // Starvation only accumulates while instruction fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_grant_data) begin
      if (!instr_req)                              r_starve <= '0;
      else if (r_starve != SC_W'(STARVE_LIMIT))    r_starve <= r_starve + SC_W'(1);
    end else if (w_grant_instr) begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_burst   <= '0;
      r_mem_bstrobe <= '0;
      r_grant_data  <= 1'b0;
    end else if (w_grant_data) begin
      r_mem_req     <= 1'b1;
      r_mem_write   <= data_write;
      r_mem_addr    <= data_addr;
      r_mem_burst   <= data_burst;
      r_mem_bstrobe <= data_bstrobe;
      r_grant_data  <= 1'b1;
    end else if (w_grant_instr) begin
      r_mem_req     <= 1'b1;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= instr_addr;
      r_mem_burst   <= instr_burst;
      r_mem_bstrobe <= instr_bstrobe;
      r_grant_data  <= 1'b0;
    end else if (w_last_beat) begin
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_grant_data  <= 1'b0;
    end
  end

  always_comb begin
    instr_ready    = 1'b0;
    instr_stall    = instr_req;
    instr_data     = '0;
    data_ready     = 1'b0;
    data_stall     = data_req;
    data_read_data = '0;
    mem_write_data = '0;
    case (r_state)
      ARB_INSTR: begin
        instr_ready = mem_ready;
        instr_stall = mem_stall;
        instr_data  = mem_read_data;
      end
      ARB_DATA: begin
        data_ready     = mem_ready;
        data_stall     = mem_stall;
        data_read_data = mem_read_data;
        mem_write_data = r_mem_write ? data_write_data : '0;
      end
      default: ;
    endcase
  end

  assign mem_req     = r_mem_req;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_burst   = r_mem_burst;
  assign mem_bstrobe = r_mem_bstrobe;
  assign grant_data  = r_grant_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, hand-written burst/starvation/reset
// sequences and random traffic, all against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, data_req, data_write;
  logic [31:0] instr_addr, data_addr, data_write_data, mem_read_data;
  logic [1:0]  instr_burst, data_burst;
  logic [3:0]  instr_bstrobe, data_bstrobe;
  logic        mem_stall, mem_ready;
  logic [31:0] instr_data, data_read_data, mem_addr, mem_write_data;
  logic        instr_ready, instr_stall, data_ready, data_stall;
  logic        mem_req, mem_write, grant_data;
  logic [1:0]  mem_burst;
  logic [3:0]  mem_bstrobe;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_burst(instr_burst),
    .instr_bstrobe(instr_bstrobe), .instr_data(instr_data), .instr_ready(instr_ready),
    .instr_stall(instr_stall),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_burst(data_burst), .data_bstrobe(data_bstrobe),
    .data_read_data(data_read_data), .data_ready(data_ready), .data_stall(data_stall),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_burst(mem_burst),
    .mem_bstrobe(mem_bstrobe), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall), .mem_ready(mem_ready),
    .grant_data(grant_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0=none 1=instr 2=data, beats remaining in transaction.
  int          m_owner = 0, m_left = 0, m_starve = 0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_burst = '0;
  logic [3:0]  m_bstrobe = '0;
  int          beats_tab [4] = '{1, 4, 8, 16};

  logic        o_req, o_gd, o_ir, o_dr, o_is, o_ds, o_wr;
  logic [31:0] o_addr;

  typedef struct {
    logic ir, dr, dw;
    logic [1:0] ib, db;
    logic [31:0] ia, da;
    logic mr, ms;
    logic e_req, e_gd, e_ir, e_dr, e_is, e_ds, e_wr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("mem_req", mem_req, m_owner != 0);
    chk("grant_data", grant_data, m_owner == 2);
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_burst", mem_burst, m_burst);
      chk("mem_bstrobe", mem_bstrobe, m_bstrobe);
      chk("mem_write", mem_write, m_write);
    end
    chk("instr_ready", instr_ready, (m_owner == 1) ? mem_ready : 1'b0);
    chk("instr_stall", instr_stall, (m_owner == 1) ? mem_stall : instr_req);
    chk("instr_data", instr_data, (m_owner == 1) ? mem_read_data : 32'h0);
    chk("data_ready", data_ready, (m_owner == 2) ? mem_ready : 1'b0);
    chk("data_stall", data_stall, (m_owner == 2) ? mem_stall : data_req);
    chk("data_read_data", data_read_data, (m_owner == 2) ? mem_read_data : 32'h0);
    chk("mem_write_data", mem_write_data, (m_owner == 2 && m_write) ? data_write_data : 32'h0);
    o_req = mem_req; o_gd = grant_data; o_ir = instr_ready; o_dr = data_ready;
    o_is = instr_stall; o_ds = data_stall; o_wr = mem_write; o_addr = mem_addr;
    @(posedge clk);
    if (reset) begin
      m_owner = 0; m_left = 0; m_starve = 0; m_write = 1'b0;
    end else if (m_owner == 0) begin
      if (data_req && !(instr_req && m_starve == LIMIT)) begin
        m_owner = 2; m_left = beats_tab[data_burst]; m_write = data_write;
        m_addr = data_addr; m_burst = data_burst; m_bstrobe = data_bstrobe;
        m_starve = instr_req ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
      end else if (instr_req) begin
        m_owner = 1; m_left = beats_tab[instr_burst]; m_write = 1'b0;
        m_addr = instr_addr; m_burst = instr_burst; m_bstrobe = instr_bstrobe;
        m_starve = 0;
      end
    end else if (mem_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_owner = 0; m_write = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_write = 0;
    instr_burst = 0; data_burst = 0; instr_addr = 0; data_addr = 0;
    instr_bstrobe = 4'hF; data_bstrobe = 4'h3;
    mem_ready = 0; mem_stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, addr_bad, ds_bad;
    logic started, done, prev_req;
    int g [$];

    idle_inputs();
    data_write_data = 32'h1234_5678; mem_read_data = 32'hCAFE_0001;
    reset = 1; instr_req = 1; data_req = 1;
    @(posedge clk); #1;

    // Reset state: idle, stall mirrors request.
    step();
    chk("rst_mem_req", o_req, 0);
    chk("rst_grant_data", o_gd, 0);
    chk("rst_instr_stall", o_is, 1);
    chk("rst_data_stall", o_ds, 1);
    reset = 0; idle_inputs();

    //            ir dr dw ib  db  ia        da        mr ms  req gd ir dr is ds wr addr
    tbl[0]  = '{1, 0, 0, 2'd0, 2'd0, 32'h100, 32'h0,   0, 0,  0, 0, 0, 0, 1, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 0, 2'd0, 2'd0, 32'h100, 32'h0,   1, 0,  1, 0, 1, 0, 0, 0, 0, 32'h100};
    tbl[2]  = '{0, 0, 0, 2'd0, 2'd0, 32'h0,   32'h0,   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[3]  = '{1, 1, 1, 2'd0, 2'd1, 32'h200, 32'h300, 0, 0,  0, 0, 0, 0, 1, 1, 0, 32'h0};
    tbl[4]  = '{1, 1, 1, 2'd0, 2'd1, 32'h200, 32'h300, 1, 0,  1, 1, 0, 1, 1, 0, 1, 32'h300};
    tbl[5]  = '{1, 1, 1, 2'd0, 2'd1, 32'h200, 32'h300, 1, 0,  1, 1, 0, 1, 1, 0, 1, 32'h300};
    tbl[6]  = '{1, 1, 1, 2'd0, 2'd1, 32'h200, 32'h300, 0, 1,  1, 1, 0, 0, 1, 1, 1, 32'h300};
    tbl[7]  = '{1, 1, 1, 2'd0, 2'd1, 32'h200, 32'h300, 1, 0,  1, 1, 0, 1, 1, 0, 1, 32'h300};
    tbl[8]  = '{1, 0, 1, 2'd0, 2'd1, 32'h200, 32'h300, 1, 0,  1, 1, 0, 1, 1, 0, 1, 32'h300};
    tbl[9]  = '{1, 0, 0, 2'd0, 2'd0, 32'h200, 32'h0,   0, 0,  0, 0, 0, 0, 1, 0, 0, 32'h0};
    tbl[10] = '{1, 0, 0, 2'd0, 2'd0, 32'h200, 32'h0,   1, 0,  1, 0, 1, 0, 0, 0, 0, 32'h200};
    tbl[11] = '{0, 0, 0, 2'd0, 2'd0, 32'h0,   32'h0,   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      instr_req = tbl[i].ir; data_req = tbl[i].dr; data_write = tbl[i].dw;
      instr_burst = tbl[i].ib; data_burst = tbl[i].db;
      instr_addr = tbl[i].ia; data_addr = tbl[i].da;
      mem_ready = tbl[i].mr; mem_stall = tbl[i].ms;
      mem_read_data = 32'hA500_0000 | i; data_write_data = 32'h5A00_0000 | i;
      step();
      chk($sformatf("vec%0d_req", i), o_req, tbl[i].e_req);
      chk($sformatf("vec%0d_gd", i), o_gd, tbl[i].e_gd);
      chk($sformatf("vec%0d_iready", i), o_ir, tbl[i].e_ir);
      chk($sformatf("vec%0d_dready", i), o_dr, tbl[i].e_dr);
      chk($sformatf("vec%0d_istall", i), o_is, tbl[i].e_is);
      chk($sformatf("vec%0d_dstall", i), o_ds, tbl[i].e_ds);
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_write", i), o_wr, tbl[i].e_wr);
        chk($sformatf("vec%0d_addr", i), o_addr, tbl[i].e_addr);
      end
    end

    // Starvation: back-to-back single-beat data grants, the fifth must go to instruction.
    do_reset();
    instr_req = 1; data_req = 1; mem_ready = 1;
    prev_req = 0;
    for (int k = 0; k < 80 && g.size() < 6; k++) begin
      step();
      if (o_req && !prev_req) g.push_back(o_gd);
      prev_req = o_req;
    end
    chk("starve_grant_count", g.size(), 6);
    for (int i = 0; i < g.size(); i++)
      chk($sformatf("starve_grant%0d_is_data", i), g[i], (i == 4) ? 0 : 1);

    // 16-beat instruction burst with stalls; data request arrives mid-burst.
    do_reset();
    instr_req = 1; instr_burst = 2'b11; instr_addr = 32'h4000;
    pulses = 0; addr_bad = 0; ds_bad = 0; started = 0; done = 0;
    for (int k = 0; k < 120 && !done; k++) begin
      mem_ready = (k % 3 == 2); mem_stall = (k % 3 == 0);
      if (k == 2) instr_req = 0;
      if (k == 6) data_req = 1;
      step();
      if (o_req && !o_gd) begin
        started = 1;
        if (o_ir) pulses++;
        if (o_addr != 32'h4000) addr_bad++;
        if (data_req && !o_ds) ds_bad++;
      end else if (started) begin
        done = 1;
      end
    end
    chk("burst16_done", done, 1);
    chk("burst16_pulses", pulses, 16);
    chk("burst16_addr_changes", addr_bad, 0);
    chk("burst16_data_not_stalled", ds_bad, 0);

    // Data requester drops after two beats of eight.
    do_reset();
    data_req = 1; data_burst = 2'b10; data_addr = 32'h800; mem_ready = 1;
    pulses = 0; started = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (pulses >= 2) data_req = 0;
      step();
      if (o_req && o_gd) begin
        started = 1;
        if (o_dr) pulses++;
      end else if (started) begin
        done = 1;
      end
    end
    chk("drop_done", done, 1);
    chk("drop_beats", pulses, 8);

    // Reset in the middle of an 8-beat burst, then a fresh grant.
    do_reset();
    instr_req = 1; instr_burst = 2'b10; instr_addr = 32'h900; mem_ready = 1;
    pulses = 0;
    for (int k = 0; k < 20 && pulses < 3; k++) begin
      step();
      if (o_ir) pulses++;
    end
    chk("rstmid_beats_before", pulses, 3);
    reset = 1; instr_req = 0; data_req = 1;
    step();
    reset = 0; data_req = 0; instr_req = 1; instr_burst = 2'b00; instr_addr = 32'hA00;
    step();
    chk("rstmid_mem_req", o_req, 0);
    chk("rstmid_grant_data", o_gd, 0);
    chk("rstmid_iready", o_ir, 0);
    chk("rstmid_dready", o_dr, 0);
    chk("rstmid_istall", o_is, 1);
    chk("rstmid_addr", o_addr, 0);
    step();
    chk("rstmid_regrant_req", o_req, 1);
    chk("rstmid_regrant_gd", o_gd, 0);
    chk("rstmid_regrant_addr", o_addr, 32'hA00);
    chk("rstmid_regrant_ready", o_ir, 1);
    instr_req = 0;
    step();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int r;
      reset = ($urandom_range(0, 199) == 0);
      instr_req = ($urandom_range(0, 3) != 0);
      data_req = ($urandom_range(0, 2) != 0);
      data_write = $urandom_range(0, 1);
      instr_burst = $urandom_range(0, 3); data_burst = $urandom_range(0, 3);
      instr_addr = $urandom; data_addr = $urandom;
      instr_bstrobe = $urandom_range(0, 15); data_bstrobe = $urandom_range(0, 15);
      data_write_data = $urandom; mem_read_data = $urandom;
      r = $urandom_range(0, 2);
      mem_ready = (r == 0); mem_stall = (r == 1);
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
